// File: rtl/usxgmii_link_fault_monitor.sv
// Multi-channel XGMII RX link-fault detector: counts consecutive LF/RF sequence ordered sets
// per channel and reports a registered fault status plus a one-cycle change pulse.
module usxgmii_link_fault_monitor #(
    parameter int NUM_CH     = 1,
    parameter int DATA_W     = 32,
    parameter int COL_WIN    = 128,
    parameter int SEQ_THRESH = 4
) (
    input  logic                       rx_312_5_clk,
    input  logic                       rx_rst,
    input  logic [NUM_CH-1:0]          xgmii_rx_valid,
    input  logic [NUM_CH*DATA_W-1:0]   xgmii_rx_data,
    input  logic [NUM_CH*DATA_W/8-1:0] xgmii_rx_control,
    output logic [2*NUM_CH-1:0]        link_fault_status_data,
    output logic [NUM_CH-1:0]          link_fault_change
);

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } fault_t;

    localparam int COLS = DATA_W / 32;
    localparam int CW   = $clog2(COL_WIN + 1);
    localparam int SW   = $clog2(SEQ_THRESH + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COL_WIN);
    localparam logic [SW-1:0] SEQ_MAX = SW'(SEQ_THRESH);

    // Returns the sequence type of one column; LF_OK means a plain column.
    function automatic fault_t col_type(input logic [31:0] d, input logic [3:0] c);
        col_type = LF_OK;
        if (c == 4'b0001 && d[23:0] == 24'h00_009C) begin
            if (d[31:24] == 8'h01)
                col_type = LF_LOCAL;
            else if (d[31:24] == 8'h02)
                col_type = LF_REMOTE;
        end
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // xgmii_rx_valid qualifies the whole word: when low, nothing in this channel moves.
        fault_t              status_q, status_d;
        fault_t              last_q, last_d;
        logic [CW-1:0]       col_q, col_d;
        logic [SW-1:0]       seq_q, seq_d;
        logic                change_q, change_d;
        fault_t              col_t [COLS];
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] ctrl;

        assign data = xgmii_rx_data[ch*DATA_W +: DATA_W];
        assign ctrl = xgmii_rx_control[ch*(DATA_W/8) +: DATA_W/8];

        always_comb begin
            for (int c = 0; c < COLS; c++)
                col_t[c] = col_type(data[c*32 +: 32], ctrl[c*4 +: 4]);
        end

        // Columns are applied in lane order, so column 1 sees column 0's updated counters.
        always_comb begin
            status_d = status_q;
            last_d   = last_q;
            col_d    = col_q;
            seq_d    = seq_q;
            change_d = 1'b0;
            if (xgmii_rx_valid[ch]) begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_t[c] != LF_OK) begin
                        if (col_t[c] == last_d && col_d < COL_MAX) begin
                            if (seq_d < SEQ_MAX)
                                seq_d = seq_d + SW'(1);
                        end else begin
                            seq_d  = SW'(1);
                            last_d = col_t[c];
                        end
                        col_d = '0;
                        if (seq_d == SEQ_MAX)
                            status_d = col_t[c];
                    end else begin
                        if (col_d < COL_MAX)
                            col_d = col_d + CW'(1);
                        if (col_d == COL_MAX) begin
                            seq_d    = '0;
                            last_d   = LF_OK;
                            status_d = LF_OK;
                        end
                    end
                end
                change_d = (status_d != status_q);
            end
        end

        always_ff @(posedge rx_312_5_clk or posedge rx_rst) begin
            if (rx_rst) begin
                status_q <= LF_OK;
                last_q   <= LF_OK;
                col_q    <= '0;
                seq_q    <= '0;
                change_q <= 1'b0;
            end else begin
                status_q <= status_d;
                last_q   <= last_d;
                col_q    <= col_d;
                seq_q    <= seq_d;
                change_q <= change_d;
            end
        end

        assign link_fault_status_data[2*ch +: 2] = status_q;
        assign link_fault_change[ch]             = change_q;
    end

endmodule

// File: tb/tb_usxgmii_link_fault_monitor.sv
// Bench for usxgmii_link_fault_monitor: a 2-channel 32-bit instance and a 1-channel 64-bit
// instance, checked against a per-column reference model of the fault rules.
module tb_usxgmii_link_fault_monitor;

    localparam int COL_WIN    = 128;
    localparam int SEQ_THRESH = 4;
    localparam logic [31:0] D_LF   = 32'h0100_009C;
    localparam logic [31:0] D_RF   = 32'h0200_009C;
    localparam logic [31:0] D_IDLE = 32'h0707_0707;
    localparam logic [31:0] D_BAD  = 32'h0100_059C;
    localparam logic [3:0]  C_SEQ  = 4'b0001;
    localparam logic [3:0]  C_IDLE = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  a_valid = '0;
    logic [63:0] a_data = '0;
    logic [7:0]  a_ctrl = '0;
    logic [3:0]  a_stat;
    logic [1:0]  a_chg;
    logic [0:0]  b_valid = '0;
    logic [63:0] b_data = '0;
    logic [7:0]  b_ctrl = '0;
    logic [1:0]  b_stat;
    logic [0:0]  b_chg;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0/1 = dut_a ch0/ch1, index 2 = dut_b.
    int   m_gap [3];
    int   m_run [3];
    int   m_type[3];
    int   m_st  [3];
    logic m_chg [3];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    usxgmii_link_fault_monitor #(.NUM_CH(2), .DATA_W(32), .COL_WIN(COL_WIN), .SEQ_THRESH(SEQ_THRESH)) dut_a (
        .rx_312_5_clk          (clk),
        .rx_rst                (rst),
        .xgmii_rx_valid        (a_valid),
        .xgmii_rx_data         (a_data),
        .xgmii_rx_control      (a_ctrl),
        .link_fault_status_data(a_stat),
        .link_fault_change     (a_chg)
    );

    usxgmii_link_fault_monitor #(.NUM_CH(1), .DATA_W(64), .COL_WIN(COL_WIN), .SEQ_THRESH(SEQ_THRESH)) dut_b (
        .rx_312_5_clk          (clk),
        .rx_rst                (rst),
        .xgmii_rx_valid        (b_valid),
        .xgmii_rx_data         (b_data),
        .xgmii_rx_control      (b_ctrl),
        .link_fault_status_data(b_stat),
        .link_fault_change     (b_chg)
    );

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_gap[m] = 0; m_run[m] = 0; m_type[m] = 0; m_st[m] = 0; m_chg[m] = 1'b0;
        end
    endtask

    task automatic model_col(input int m, input logic [3:0] c, input logic [31:0] d);
        int t;
        t = 0;
        if (c == C_SEQ && d == D_LF) t = 1;
        else if (c == C_SEQ && d == D_RF) t = 2;
        if (t != 0) begin
            if (t == m_type[m] && m_gap[m] < COL_WIN) m_run[m]++;
            else begin m_run[m] = 1; m_type[m] = t; end
            m_gap[m] = 0;
            if (m_run[m] >= SEQ_THRESH) m_st[m] = t;
        end else begin
            m_gap[m]++;
            if (m_gap[m] >= COL_WIN) begin m_run[m] = 0; m_type[m] = 0; m_st[m] = 0; end
        end
    endtask

    function automatic logic [3:0] exp_a_stat();
        return {2'(m_st[1]), 2'(m_st[0])};
    endfunction

    function automatic logic [1:0] exp_a_chg();
        return {m_chg[1], m_chg[0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic [1:0] av, input logic [63:0] ad, input logic [7:0] ac,
                        input logic bv, input logic [63:0] bd, input logic [7:0] bc);
        int old;
        @(negedge clk);
        a_valid = av; a_data = ad; a_ctrl = ac;
        b_valid = bv; b_data = bd; b_ctrl = bc;
        for (int ch = 0; ch < 2; ch++) begin
            old = m_st[ch];
            if (av[ch]) model_col(ch, ac[ch*4 +: 4], ad[ch*32 +: 32]);
            m_chg[ch] = (m_st[ch] != old);
        end
        old = m_st[2];
        if (bv) begin
            model_col(2, bc[3:0], bd[31:0]);
            model_col(2, bc[7:4], bd[63:32]);
        end
        m_chg[2] = (m_st[2] != old);
        @(posedge clk);
        #1;
    endtask

    task automatic a_word(input logic [31:0] d0, input logic [3:0] c0,
                          input logic [31:0] d1, input logic [3:0] c1);
        step(2'b11, {d1, d0}, {c1, c0}, 1'b0, {$urandom, $urandom}, 8'(C_IDLE));
    endtask

    function automatic void rand_col(input int p_seq, input int fav, output logic [3:0] c, output logic [31:0] d);
        int r;
        logic [31:0] flip;
        r = $urandom_range(0, 999);
        if (r < p_seq) begin
            c = C_SEQ;
            d = ($urandom_range(0, 9) < 9) ? ((fav == 1) ? D_LF : D_RF) : ((fav == 1) ? D_RF : D_LF);
        end else if (r < p_seq + 30) begin
            flip = 32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3));
            c = C_SEQ;
            d = D_LF ^ flip;
        end else if (r < p_seq + 50) begin
            c = 4'($urandom);
            d = $urandom;
        end else begin
            c = C_IDLE;
            d = D_IDLE;
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_stat, a_chg, b_stat, b_chg} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", {a_stat, a_chg, b_stat, b_chg}, 9'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lf_threshold();
        int pulses;
        pulses = 0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                for (int i = 0; i < 10; i++) begin
                    a_word(D_IDLE, C_IDLE, D_IDLE, C_IDLE);
                    pulses += int'(a_chg[0]);
                    checks++;
                    if ({a_stat, a_chg} !== {exp_a_stat(), exp_a_chg()}) begin
                        errors++;
                        $display("FAIL lf_thresh_idle: got %b required %b", {a_stat, a_chg}, {exp_a_stat(), exp_a_chg()});
                    end
                end
            end
            a_word(D_LF, C_SEQ, D_IDLE, C_IDLE);
            pulses += int'(a_chg[0]);
            checks++;
            if ({a_stat, a_chg} !== {exp_a_stat(), exp_a_chg()}) begin
                errors++;
                $display("FAIL lf_thresh_seq%0d: got %b required %b", s, {a_stat, a_chg}, {exp_a_stat(), exp_a_chg()});
            end
        end
        checks++;
        if (a_stat !== 4'b0001) begin
            errors++;
            $display("FAIL lf_thresh_status: got %b required %b", a_stat, 4'b0001);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL lf_thresh_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_clear_window();
        int bad;
        bad = 0;
        for (int i = 0; i < 127; i++) begin
            a_word(D_IDLE, C_IDLE, D_IDLE, C_IDLE);
            if (a_stat[1:0] !== 2'b01 || a_chg[0] !== 1'b0) bad++;
        end
        a_word(D_LF, C_SEQ, D_IDLE, C_IDLE);
        if (a_stat[1:0] !== 2'b01 || a_chg[0] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gap_127_hold: got %0d bad cycles required 0", bad);
        end
        for (int i = 0; i < 128; i++) begin
            a_word(D_IDLE, C_IDLE, D_IDLE, C_IDLE);
            if (i == 126) begin
                checks++;
                if (a_stat[1:0] !== 2'b01) begin
                    errors++;
                    $display("FAIL gap_127th_idle: got %b required %b", a_stat[1:0], 2'b01);
                end
            end
        end
        checks++;
        if ({a_stat[1:0], a_chg[0]} !== 3'b001) begin
            errors++;
            $display("FAIL gap_128_clear: got %b required %b", {a_stat[1:0], a_chg[0]}, 3'b001);
        end
        checks++;
        if ({a_stat, a_chg} !== {exp_a_stat(), exp_a_chg()}) begin
            errors++;
            $display("FAIL gap_model: got %b required %b", {a_stat, a_chg}, {exp_a_stat(), exp_a_chg()});
        end
    endtask

    task automatic test_lf_to_rf();
        int pulses;
        pulses = 0;
        repeat (4) a_word(D_LF, C_SEQ, D_IDLE, C_IDLE);
        checks++;
        if (a_stat[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL lf_b2b: got %b required %b", a_stat[1:0], 2'b01);
        end
        for (int i = 0; i < 4; i++) begin
            a_word(D_RF, C_SEQ, D_IDLE, C_IDLE);
            pulses += int'(a_chg[0]);
            checks++;
            if (a_stat[1:0] !== ((i == 3) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lf_to_rf_%0d: got %b required %b", i, a_stat[1:0], (i == 3) ? 2'b10 : 2'b01);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL lf_to_rf_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_mid_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_stat, a_chg, b_stat, b_chg} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset: got %b required %b", {a_stat, a_chg, b_stat, b_chg}, 9'b0);
        end
        a_valid = '0;
        b_valid = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_word(D_LF, C_SEQ, D_LF, C_SEQ);
            checks++;
            if ({a_stat, a_chg} !== 6'b0) begin
                errors++;
                $display("FAIL post_reset_lf%0d: got %b required %b", i, {a_stat, a_chg}, 6'b0);
            end
        end
    endtask

    task automatic test_wide();
        int gap;
        for (int w = 0; w < 2; w++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1)
                    step(2'b00, 64'h0, 8'h0, 1'b0, {D_RF, D_RF}, {C_SEQ, C_SEQ});
                else
                    step(2'b00, 64'h0, 8'h0, 1'b0, {$urandom, $urandom}, 8'($urandom));
                checks++;
                if ({b_stat, b_chg} !== {2'(m_st[2]), m_chg[2]} || b_chg !== 1'b0) begin
                    errors++;
                    $display("FAIL wide_invalid: got %b required %b", {b_stat, b_chg}, {2'(m_st[2]), 1'b0});
                end
            end
            step(2'b00, 64'h0, 8'h0, 1'b1, {D_RF, D_RF}, {C_SEQ, C_SEQ});
            checks++;
            if ({b_stat, b_chg} !== ((w == 1) ? 3'b101 : 3'b000)) begin
                errors++;
                $display("FAIL wide_word%0d: got %b required %b", w, {b_stat, b_chg}, (w == 1) ? 3'b101 : 3'b000);
            end
        end
    endtask

    task automatic test_channels();
        repeat (4) a_word(D_LF, C_SEQ, D_IDLE, C_IDLE);
        checks++;
        if (a_stat !== 4'b0001) begin
            errors++;
            $display("FAIL ch_independent: got %b required %b", a_stat, 4'b0001);
        end
        repeat (4) a_word(D_IDLE, C_IDLE, D_LF, C_SEQ);
        for (int i = 0; i < 127; i++) begin
            a_word(D_IDLE, C_IDLE, D_IDLE, C_IDLE);
            checks++;
            if ({a_stat, a_chg} !== {exp_a_stat(), exp_a_chg()}) begin
                errors++;
                $display("FAIL ch_idle_%0d: got %b required %b", i, {a_stat, a_chg}, {exp_a_stat(), exp_a_chg()});
            end
        end
        checks++;
        if (a_stat[3:2] !== 2'b01) begin
            errors++;
            $display("FAIL ch1_before_bad: got %b required %b", a_stat[3:2], 2'b01);
        end
        a_word(D_IDLE, C_IDLE, D_BAD, C_SEQ);
        checks++;
        if ({a_stat[3:2], a_chg[1]} !== 3'b001) begin
            errors++;
            $display("FAIL ch1_malformed_plain: got %b required %b", {a_stat[3:2], a_chg[1]}, 3'b001);
        end
    endtask

    task automatic test_random();
        int p_seq;
        int fav;
        logic [1:0]  av;
        logic [63:0] ad, bd;
        logic [7:0]  ac, bc;
        logic [31:0] d;
        logic [3:0]  c;
        p_seq = 500;
        fav = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: p_seq = 500;
                    1: p_seq = 60;
                    default: p_seq = 4;
                endcase
                fav = $urandom_range(1, 2);
            end
            av[0] = ($urandom_range(0, 9) != 0);
            av[1] = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < 2; k++) begin
                rand_col(p_seq, fav, c, d);
                ad[k*32 +: 32] = d; ac[k*4 +: 4] = c;
                rand_col(p_seq, fav, c, d);
                bd[k*32 +: 32] = d; bc[k*4 +: 4] = c;
            end
            step(av, ad, ac, ($urandom_range(0, 9) != 0), bd, bc);
            checks++;
            if ({a_stat, a_chg, b_stat, b_chg} !== {exp_a_stat(), exp_a_chg(), 2'(m_st[2]), m_chg[2]}) begin
                errors++;
                $display("FAIL random_cyc%0d: got %b required %b", cyc, {a_stat, a_chg, b_stat, b_chg},
                         {exp_a_stat(), exp_a_chg(), 2'(m_st[2]), m_chg[2]});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lf_threshold();
        test_clear_window();
        test_lf_to_rf();
        test_mid_reset();
        test_wide();
        test_channels();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
